// File: rtl/regfile.sv
// Two-read / one-write register file at the write-back end of the execute path.
// Optional write-through bypass on the read ports: define REGFILE_BYPASS_EN.

module regfile_rport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic                             rst,
  input  logic                             re,
  input  logic [ADDR_W-1:0]                raddr,
  input  logic                             byp_hit,
  input  logic [DATA_W-1:0]                wdata,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q,
  output logic [DATA_W-1:0]                rdata
);
  always_comb begin
    rdata = '0;
    if (rst || !re || raddr == '0) rdata = '0;
    else if (byp_hit)              rdata = wdata;
    else                           rdata = regs_q[raddr];
  end
endmodule

module regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NUM_RP = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_RP-1:0]               rp_re, rp_hit;
  logic [NUM_RP-1:0][ADDR_W-1:0]   rp_addr;
  logic [NUM_RP-1:0][DATA_W-1:0]   rp_data;
  logic                            wr_ok;

  assign wr_ok = !rst && we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (rst)        regs_d = '0;
    else if (wr_ok) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) regs_q <= regs_d;

  assign rp_re   = {re2, re1};
  assign rp_addr = {raddr2, raddr1};

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
`ifdef REGFILE_BYPASS_EN
    // Decode sees the value being committed this cycle, hiding the WB hazard.
    assign rp_hit[p] = wr_ok && (rp_addr[p] == waddr);
`else
    assign rp_hit[p] = 1'b0;
`endif
    regfile_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rport (
      .rst    (rst),
      .re     (rp_re[p]),
      .raddr  (rp_addr[p]),
      .byp_hit(rp_hit[p]),
      .wdata  (wdata),
      .regs_q (regs_q),
      .rdata  (rp_data[p])
    );
  end

  assign rdata1 = rp_data[0];
  assign rdata2 = rp_data[1];
endmodule

// File: tb/tb_regfile.sv
// Scoreboarded bench for regfile: directed plan cases then random traffic
// against an array reference model.

module tb_regfile;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst, we, re1, re2;
  logic [AW-1:0] waddr, raddr1, raddr2;
  logic [DW-1:0] wdata, rdata1, rdata2;

  regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mem [NR];
  int            errors = 0;
  int            checks = 0;

  function automatic logic [DW-1:0] model_read(input logic r, input logic w,
      input int wa, input logic [DW-1:0] wd, input logic re, input int ra);
    if (r || !re || ra == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (w && wa != 0 && wa == ra) return wd;
`endif
    return mem[ra];
  endfunction

  task automatic cyc(input string name, input logic r, input logic w, input int wa,
      input logic [DW-1:0] wd, input logic e1, input int a1, input logic e2, input int a2);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = AW'(wa); wdata = wd;
    re1 = e1; raddr1 = AW'(a1); re2 = e2; raddr2 = AW'(a2);
    x.name = name;
    x.e1 = model_read(r, w, wa, wd, e1, a1);
    x.e2 = model_read(r, w, wa, wd, e2, a2);
    sb.push_back(x);
    // model commits on the coming edge
    if (r) for (int i = 0; i < NR; i++) mem[i] = '0;
    else if (w && wa != 0) mem[wa] = wd;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks += 2;
      if (rdata1 !== x.e1) begin
        errors++;
        $display("FAIL %s port1: got %h expected %h", x.name, rdata1, x.e1);
      end
      if (rdata2 !== x.e2) begin
        errors++;
        $display("FAIL %s port2: got %h expected %h", x.name, rdata2, x.e2);
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) mem[i] = 'x;
    rst = 1; we = 0; waddr = 0; wdata = 0; re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;

    cyc("reset_state", 1, 0, 0, 0, 1, 1, 1, 31);
    cyc("reset_read", 0, 0, 0, 0, 1, 5, 1, 17);

    // 1: reset clears preloaded r5
    cyc("t1_preload", 0, 1, 5, 32'h1234_5678, 0, 0, 0, 0);
    cyc("t1_pre_rst", 0, 0, 0, 0, 1, 5, 1, 5);
    cyc("t1_rst", 1, 0, 0, 0, 1, 5, 1, 5);
    cyc("t1_after", 0, 0, 0, 0, 1, 5, 1, 5);
    // 2: basic write then dual read
    cyc("t2_write", 0, 1, 3, 32'hDEAD_BEEF, 0, 3, 0, 3);
    cyc("t2_read", 0, 0, 0, 0, 1, 3, 1, 3);
    // 3: r0 immutable
    cyc("t3_wr0", 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0);
    cyc("t3_after", 0, 0, 0, 0, 1, 0, 1, 0);
    // 4: same-cycle read of write target
    cyc("t4_pre", 0, 1, 7, 32'h11, 0, 0, 0, 0);
    cyc("t4_same", 0, 1, 7, 32'hA5A5_A5A5, 1, 7, 1, 7);
    cyc("t4_next", 0, 0, 0, 0, 1, 7, 1, 7);
    // 5: read disable and reset masking
    cyc("t5_pre", 0, 1, 9, 32'h55, 0, 0, 0, 0);
    cyc("t5_re0", 0, 0, 0, 0, 0, 9, 1, 9);
    cyc("t5_rst", 1, 0, 0, 0, 1, 9, 1, 9);
    cyc("t5_post", 0, 0, 0, 0, 1, 9, 1, 9);
    // 6: reset wins over a colliding write
    cyc("t6_pre", 0, 1, 4, 32'h77, 0, 0, 0, 0);
    cyc("t6_coll", 1, 1, 4, 32'h99, 1, 4, 0, 0);
    cyc("t6_after", 0, 0, 0, 0, 1, 4, 1, 4);
    // consecutive writes to distinct registers
    cyc("b2b_a", 0, 1, 10, 32'hAAAA_0001, 0, 0, 0, 0);
    cyc("b2b_b", 0, 1, 11, 32'hBBBB_0002, 1, 10, 1, 10);
    cyc("b2b_chk", 0, 0, 0, 0, 1, 10, 1, 11);
    // top address
    cyc("r31_wr", 0, 1, 31, 32'hFFFF_FFFF, 1, 31, 1, 30);
    cyc("r31_rd", 0, 0, 0, 0, 1, 31, 1, 30);

    // random traffic; small address range raises collision rate
    for (int n = 0; n < 600; n++) begin
      logic r, w, e1, e2;
      int   wa, a1, a2;
      r  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 3) != 0);
      e1 = ($urandom_range(0, 7) != 0);
      e2 = ($urandom_range(0, 7) != 0);
      wa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, NR - 1);
      a1 = ($urandom_range(0, 1) == 0) ? wa : $urandom_range(0, NR - 1);
      a2 = ($urandom_range(0, 2) == 0) ? a1 : $urandom_range(0, NR - 1);
      cyc("random", r, w, wa, DW'($urandom), e1, a1, e2, a2);
    end

    begin
      int waitc;
      waitc = 0;
      while (sb.size() > 0 && waitc < 10) begin
        @(posedge clk);
        waitc++;
      end
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file at the write-back end of the execute result path.
- Accepts the destination address, write enable and result data that the execute stage produces and that travel down the pipeline.
- Commits that result into architectural state.
- Serves two independent read ports to the decode stage for source operands.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers (2**ADDR_W)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
we  input  1  write enable from write-back (the wreg flag carried from execute)
waddr  input  ADDR_W  destination register (the wd value carried from execute)
wdata  input  DATA_W  result to commit (the wdata value carried from execute)
re1  input  1  read enable, port 1
raddr1  input  ADDR_W  source register, port 1
rdata1  output  DATA_W  operand, port 1
re2  input  1  read enable, port 2
raddr2  input  ADDR_W  source register, port 2
rdata2  output  DATA_W  operand, port 2

Behaviour:
- Interface is fixed: one clock, clk; reset is synchronous and active-high, rst.
- Storage: NUM_REGS x DATA_W array, updated only on the clk rising edge.
- Reset: on any rising edge with rst=1, all NUM_REGS entries clear to 0.
  - Writes in that cycle are discarded.
  - While rst=1, rdata1 and rdata2 are 0 combinationally.
- Write: on a rising edge with rst=0, we=1 and waddr!=0, regs[waddr] <= wdata.
  - waddr==0 is silently dropped; r0 always reads 0.
- Read ports are combinational and independent. Priority per port (shown for port 1; port 2 is identical):
  1. rst=1 -> 0
  2. re1=0 -> 0
  3. raddr1==0 -> 0
  4. bypass hit (see Optional Feature) -> wdata
  5. otherwise -> regs[raddr1]
- Latency: a write becomes visible through the array on the cycle after its edge, i.e. 1-cycle write-to-read without bypass.
- Simultaneous events:
  - Both ports reading the same register return identical data.
  - A read and a write to the same register in one cycle follow the Optional Feature rules.
  - Writes to distinct registers in consecutive cycles both land.
- Reset mid-stream: rst asserted in the same cycle as we=1 leaves the register at 0, not wdata.
- No X propagation: every register has a defined value after the first reset edge.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: write-through bypass.
  - If rst=0, we=1, waddr!=0, reN=1 and raddrN==waddr, then rdataN = wdata in the same cycle.
  - Covers the decode/write-back hazard without an extra stall.
- Undefined: no bypass; rdataN returns the pre-edge array value. The pipeline handles that hazard elsewhere.
- Both builds must pass the test plan; case 4 has per-build expectations.

Test Plan:
1. Reset clears: preload r5=0x1234_5678, pulse rst for one edge -> rdata1 (re1=1, raddr1=5) reads 0x0000_0000 after the edge.
2. Basic write/read: we=1, waddr=3, wdata=0xDEAD_BEEF for one edge, then re1=1, raddr1=3 and re2=1, raddr2=3 -> both ports read 0xDEAD_BEEF.
3. r0 immutable: we=1, waddr=0, wdata=0xFFFF_FFFF -> re1=1, raddr1=0 reads 0 in the write cycle and after the edge.
4. Same-cycle read of write target: we=1, waddr=7, wdata=0xA5A5_A5A5, re2=1, raddr2=7, r7 previously 0x11 -> rdata2=0xA5A5_A5A5 with REGFILE_BYPASS_EN, 0x0000_0011 without; both builds read 0xA5A5_A5A5 next cycle.
5. Read disable: r9=0x55, re1=0, raddr1=9 -> rdata1=0; rst=1 with re1=1, raddr1=9 -> rdata1=0.
6. Reset vs write collision: rst=1 and we=1, waddr=4, wdata=0x99 on the same edge -> r4 reads 0 afterwards.
